// File: rtl/lzy_disp_pkg.sv
// lzy_disp_pkg: shared FSM states, segment table and defaults for the key/display blocks
package lzy_disp_pkg;
    localparam int DEB_CYCLES_DEF  = 20000;
    localparam int SCAN_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, ACCEPT, HELD} state_t;

    // gfedcba patterns, entry 7 first so SEG_LUT[v] selects digit v
    localparam logic [7:0][6:0] SEG_LUT = {7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

    function automatic logic [2:0] prio_code(input logic [7:0] k);
        prio_code = 3'd0;
        for (int i = 0; i < 8; i++)
            if (!k[i]) prio_code = 3'(i);
    endfunction
endpackage

// File: rtl/lzy_seg7_dec.sv
// lzy_seg7_dec: 3-bit value to active-high 7-segment pattern, dp always off
module lzy_seg7_dec
    import lzy_disp_pkg::*;
(
    input  logic [2:0] val,
    input  logic       blank,
    output logic [7:0] seg
);
    assign seg = blank ? 8'h00 : {1'b0, SEG_LUT[val]};
endmodule

// File: rtl/lzy_disp_scan_ctrl.sv
// lzy_disp_scan_ctrl: debounced priority key capture feeding a 4-digit multiplexed 7-seg display
module lzy_disp_scan_ctrl
    import lzy_disp_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int SCAN_CYCLES = SCAN_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ei_n,
    input  logic [7:0] key_n,
    input  logic       clr,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic [2:0] code,
    output logic       code_valid,
    output logic [7:0] press_cnt
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES + 1);

    logic [7:0]      ks_m, ks, cap;
    logic            eis_m, eis;
    state_t          state, state_nxt;
    logic [DW-1:0]   cnt, cnt_nxt;
    logic            deb_done;
    logic [SW-1:0]   scnt;
    logic            scan_wrap;
    logic [1:0]      idx;
    logic [3:0]      dv;
    logic [3:0][2:0] dq;
    logic [7:0]      seg_nxt;

    assign deb_done  = cnt == DW'(DEB_CYCLES - 1);
    assign scan_wrap = scnt == SW'(SCAN_CYCLES - 1);

    // one counter serves both the press debounce and the release debounce in HELD
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + DW'(1);
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!eis && ks != 8'hFF) state_nxt = DEBOUNCE;
            end
            DEBOUNCE: state_nxt = (eis || ks != cap) ? IDLE : deb_done ? ACCEPT : DEBOUNCE;
            ACCEPT: begin
                cnt_nxt   = '0;
                state_nxt = HELD;
            end
            HELD: begin
                if (ks != 8'hFF) cnt_nxt = '0;
                else if (deb_done) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_m       <= 8'hFF;
            ks         <= 8'hFF;
            eis_m      <= 1'b1;
            eis        <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
            cap        <= 8'hFF;
            code       <= 3'd0;
            code_valid <= 1'b0;
            press_cnt  <= 8'd0;
            dv         <= 4'd0;
            dq         <= '0;
        end else begin
            ks_m       <= key_n;
            ks         <= ks_m;
            eis_m      <= ei_n;
            eis        <= eis_m;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            code_valid <= state == ACCEPT;
            if (state == IDLE) cap <= ks;
            if (state == ACCEPT) begin
                code      <= prio_code(cap);
                press_cnt <= press_cnt + 8'd1;
                dq        <= {dq[2:0], prio_code(cap)};
            end
            dv <= clr ? 4'd0 : (state == ACCEPT) ? {dv[2:0], 1'b1} : dv;
        end
    end

    lzy_seg7_dec u_dec (
        .val  (dq[idx]),
        .blank(!dv[idx]),
        .seg  (seg_nxt)
    );

    // an and seg share one register stage so they always describe the same digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt <= '0;
            idx  <= 2'd0;
            an   <= 4'b1110;
            seg  <= 8'h00;
        end else begin
            scnt <= scan_wrap ? '0 : scnt + SW'(1);
            if (scan_wrap) idx <= idx + 2'd1;
            an   <= ~(4'b0001 << idx);
            seg  <= seg_nxt;
        end
    end
endmodule
